snd_decimator: RTL
==================

# snd_decimator

Synthesizable front end for sound capture. It takes the four DMG APU channel DAC codes (4 bits each) at the APU sample tick and box-filters them over 2^LOG2_DECIM ticks. It then pushes one averaged frame per window into a small FIFO with a valid/ready output. The testbench drains that FIFO at host sample rate and hands each frame to the snd_dump writer tasks (bit4→int8 per channel, mix→int16).

## Interface
Parameters:
- LOG2_DECIM, 7: window length is 2^LOG2_DECIM input ticks; legal range 1..12.
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset; one clock domain.
- in_tick  in  1  APU sample strobe; ch_in sampled only when high.
- ch_in  in  4x4  channel DAC codes, ch_in[0]=CH1 … ch_in[3]=CH4.
- out_valid  out  1  FIFO head holds a frame.
- out_ready  in  1  consumer accepts head this cycle.
- out_frame  out  snd_frame_t  ch[0..3] 4-bit means, mix 6-bit.
- overflow  out  1  sticky; a frame was dropped since reset.
- drop_count  out  8  dropped frames, saturating at 255.

## Operation
- Per channel, an accumulator of 4+LOG2_DECIM bits; tick counter of LOG2_DECIM bits.
- On in_tick: each accumulator adds ch_in[i]; counter increments, wrapping at 2^LOG2_DECIM-1 → 0.
- Window close (in_tick with counter at max):
  - frame.ch[i] = (acc[i]+ch_in[i]) >> LOG2_DECIM, truncating.
  - frame.mix = (Σ(acc[i]+ch_in[i])) >> LOG2_DECIM; 6 bits, max 60.
  - Accumulators load 0 and counter loads 0 in the same edge; no tick is lost or double-counted.
- Push rule:
  - Frame is pushed when FIFO not full, or when full with out_valid&&out_ready in the same cycle (pop and push coexist).
  - Otherwise the new frame is dropped: overflow sets, drop_count increments (saturating); FIFO contents untouched.
- Pop: out_valid&&out_ready advances head. out_frame is held stable while out_valid && !out_ready.
- in_tick low: accumulators and counter hold.
- Reset (async, any time, including mid-window or with FIFO occupied):
  - Accumulators, counter, FIFO pointers and count, overflow, drop_count → 0.
  - out_valid → 0; out_frame → all zeros.
  - No partial frame is emitted after reset release.

## Timing
- Window-closing in_tick at edge N → frame registered into FIFO at N; out_valid high after edge N when FIFO was empty. Latency is 1 cycle from the closing tick's cycle.
- FIFO is fall-through-free: out_frame is registered head storage, with no combinational path from ch_in or in_tick.
- out_ready→out_valid is combinational only through the FIFO count register; no combinational path from out_ready to out_frame.
- Back-to-back in_tick every cycle is supported: one frame per 2^LOG2_DECIM cycles.
- Full FIFO with simultaneous pop and push: occupancy unchanged, no drop.
- overflow/drop_count update on the same edge as the dropped push.

## Structure
- Package snd_pkg:
  - typedef snd_frame_t (packed struct: logic [3:0] ch [4]; logic [5:0] mix).
  - localparam NUM_CH = 4.
  - Function acc_width(log2_decim).
- Sub-module snd_fifo: generic synchronous FIFO of snd_frame_t with push/pop/full/empty and registered head.
- snd_decimator: accumulator/counter datapath and drop logic.

## Test plan
- LOG2_DECIM=2; ch_in={F,F,F,F} for 4 ticks → one frame ch={F,F,F,F}, mix=60; out_valid rises the cycle after the 4th tick.
- LOG2_DECIM=2; CH1 alternates 0,F,0,F, others 0 → ch[0]=7 (30>>2), mix=7. CH2 ticks 1,2,3,4 → ch[1]=2 (truncation check).
- in_tick asserted every 3rd cycle with gaps → frame values identical to the contiguous-tick case; counter holds across gaps.
- FIFO_DEPTH=2, out_ready=0, 3 windows → 2 frames stored, overflow=1, drop_count=1. Then pop/push in the same cycle while full → no further drops, FIFO order preserved.
- 300 windows with out_ready=0, FIFO_DEPTH=2 → drop_count saturates at 255.
- reset_n pulsed low mid-window (tick 2 of 4) with 1 frame queued → all outputs 0 immediately. The next frame after release averages only post-reset ticks.

Source files
------------

// File: rtl/snd_pkg.sv
// snd_pkg
// Shared types and helpers for the sound-capture decimator.
//   snd_frame_t : one averaged frame, four 4-bit channel means plus a 6-bit mix
//   NUM_CH      : number of APU channels (CH1..CH4)
//   acc_width() : accumulator width needed for a window of 2^log2_decim ticks
package snd_pkg;

    localparam int NUM_CH = 4;

    // Channel means are kept as a packed 2-D field so the whole frame stays
    // a packed struct and can be moved around as a single vector.
    typedef struct packed {
        logic [NUM_CH-1:0][3:0] ch;
        logic [5:0]             mix;
    } snd_frame_t;

    // A 4-bit code summed 2^log2_decim times needs log2_decim extra bits.
    function automatic int acc_width(input int log2_decim);
        return 4 + log2_decim;
    endfunction

endpackage

// File: rtl/snd_fifo.sv
// snd_fifo
// Small synchronous FIFO of snd_frame_t with a registered head.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   push         : write push_data this cycle (ignored when full and not popping)
//   push_data    : frame to enqueue
//   pop          : advance the head this cycle (ignored when empty)
//   full, empty  : occupancy flags, derived from the count register only
//   head         : frame at the head; all zeros while the FIFO is empty
module snd_fifo
    import snd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  snd_frame_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output snd_frame_t head
);

    localparam int PW = $clog2(DEPTH);

    snd_frame_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Flags come straight from the count register, so nothing from the
    // producer or consumer side reaches them combinationally.
    always_comb begin
        empty   = (count == '0);
        full    = (count == (PW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = empty ? '0 : mem[rd_ptr];
    end

    // Storage and pointers; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snd_decimator.sv
// snd_decimator
// Box-filters the four DMG APU channel DAC codes over 2^LOG2_DECIM sample
// ticks and queues one averaged frame per window in a small output FIFO.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   in_tick      : APU sample strobe, ch_in is accumulated only when high
//   ch_in        : four 4-bit DAC codes, ch_in[0] = CH1 .. ch_in[3] = CH4
//   out_valid    : FIFO head holds a frame
//   out_ready    : consumer takes the head this cycle
//   out_frame    : head frame (channel means and mix)
//   overflow     : sticky, some frame has been dropped since reset
//   drop_count   : number of dropped frames, saturating at 255
module snd_decimator
    import snd_pkg::*;
#(
    parameter int LOG2_DECIM = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_tick,
    input  logic [NUM_CH-1:0][3:0] ch_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output snd_frame_t             out_frame,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int AW = acc_width(LOG2_DECIM);

    logic [AW-1:0]         acc      [NUM_CH];
    logic [AW-1:0]         acc_next [NUM_CH];
    logic [LOG2_DECIM-1:0] tick_cnt;
    logic [AW+1:0]         mix_sum;
    snd_frame_t            new_frame;
    logic                  window_close;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // The closing frame includes the current tick's sample, so the means are
    // taken from acc + ch_in rather than from the accumulator alone.
    always_comb begin
        window_close = in_tick && (tick_cnt == '1);
        mix_sum      = '0;
        new_frame    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_next[i]      = acc[i] + AW'(ch_in[i]);
            mix_sum          = mix_sum + (AW+2)'(acc_next[i]);
            new_frame.ch[i]  = 4'(acc_next[i] >> LOG2_DECIM);
        end
        new_frame.mix = 6'(mix_sum >> LOG2_DECIM);
    end

    // A full FIFO still accepts the frame when the head leaves on the same edge.
    always_comb begin
        pop  = out_valid && out_ready;
        push = window_close && (!fifo_full || pop);
        drop = window_close && !push;
    end

    // Accumulators and tick counter; the closing tick reloads both to zero
    // so the next window starts clean without losing a sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            tick_cnt <= '0;
        end else if (in_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= window_close ? '0 : acc_next[i];
            end
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Drop bookkeeping moves on the same edge as the rejected push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    snd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (new_frame),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_frame)
    );

    assign out_valid = !fifo_empty;

endmodule
